fir_out_quant: RTL and testbench
================================

Name: fir_out_quant

Overview:
- Output stage placed directly downstream of the distributed-arithmetic FIR core.
- Takes the core's wide signed accumulated sum and rounds away FRAC_SHIFT fractional bits, then saturates the result to BIT_WIDTH.
- Optionally decimates by DECIM, then buffers samples in a 2-entry FIFO with a valid/ready interface.
- Reports saturation and dropped samples through sticky flags and counters.

Parameters:
- SUM_WIDTH, 25, width of the signed sum from the FIR core (BIT_WIDTH + clog2(taps) + clog2(BIT_WIDTH)).
- BIT_WIDTH, 16, signed output sample width.
- FRAC_SHIFT, 8, number of LSBs removed by rounding; must satisfy 1 <= FRAC_SHIFT < SUM_WIDTH.
- DECIM, 1, decimation factor; must be >= 1. DECIM=1 passes every sample.
- CNT_WIDTH, 16, width of the saturation and drop counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sum_in is valid this cycle; driven by the FIR core's clk_enable. No backpressure is applied upstream.
- sum_in  in  SUM_WIDTH  signed sum from the FIR core.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  BIT_WIDTH  signed quantised sample.
- sat_flag  out  1  sticky; set when any sample saturates.
- ovf_flag  out  1  sticky; set when any sample is dropped because the FIFO is full.
- sat_cnt  out  CNT_WIDTH  number of saturated samples; stops at all-ones.
- drop_cnt  out  CNT_WIDTH  number of dropped samples; stops at all-ones.
- clr_flags  in  1  single-cycle pulse that clears both sticky flags and both counters.

Behaviour:
- Reset: pipeline valids=0, FIFO empty, out_valid=0, out_data=0, both flags=0, both counters=0, decimation phase=0. A reset mid-operation discards all in-flight samples and samples held in the FIFO.
- Stage 1 (round), registered:
  - r = (sign-extend(sum_in) to SUM_WIDTH+1) + 2^(FRAC_SHIFT-1), then arithmetic shift right by FRAC_SHIFT.
  - This is round-half-up (toward +inf), so -1.5 rounds to -1.
  - The extra MSB prevents wrap when the input is near full scale.
- Stage 2 (saturate + decimate), registered:
  - If r > 2^(BIT_WIDTH-1)-1, clamp to max; if r < -2^(BIT_WIDTH-1), clamp to min.
  - A clamp counts as a saturation event only for samples that survive decimation.
  - Decimation phase counts 0..DECIM-1 and wraps. It advances only on valid samples. The sample taken at phase 0 is kept; all others are discarded.
  - The first valid sample after reset is always kept.
- FIFO:
  - 2 entries; head is registered onto out_data/out_valid.
  - Push occurs when a kept sample leaves stage 2. Pop occurs when out_valid and out_ready are both high.
  - Full with push and pop in the same cycle: both happen, and nothing is dropped.
  - Full with push and no pop: the new sample is dropped; ovf_flag is set and drop_cnt increments.
  - Empty with push: out_valid rises the next cycle.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Latency: in_valid at cycle t gives out_valid at t+3 when the FIFO is empty. Throughput is 1 sample/cycle.
- Flags and counters:
  - Both flags are sticky until clr_flags.
  - If clr_flags coincides with a new event, clear has priority and the event is lost.
  - Counters stop at 2^CNT_WIDTH-1 and do not wrap.
- Width rule: all arithmetic is signed; no implicit truncation before the saturation check.

Decomposition:
- Shared package (fir_pkg) holds:
  - the SUM_WIDTH derivation function (BIT_WIDTH + clog2 taps + clog2 BIT_WIDTH), shared with the FIR core;
  - saturation-limit constants for a given BIT_WIDTH;
  - the sign-extend/round helper function.
- One natural sub-module: fir_skid_fifo2, the 2-entry valid/ready FIFO with push/pop/full/empty signals, parameterised on width. It is reusable by other filter stages.

Test Plan (defaults unless stated):
1. Rounding: in_valid pulses with sum_in=384, -384, 127, 128 and out_ready=1 -> out_data 2, -1, 0, 1, each 3 cycles after its input; sat_flag stays 0.
2. Saturation: sum_in=8388607 then -16777216 -> out_data 32767 then -32768; sat_flag=1, sat_cnt=2. Then a clr_flags pulse -> both flag and counter read 0.
3. Decimation: DECIM=3, in_valid continuous, sum_in=k*256 for k=0..8 -> outputs 0, 3, 6 only.
4. Backpressure and drop: out_ready=0, 4 consecutive valid samples 1..4 -> FIFO holds 1, 2; samples 3 and 4 dropped; ovf_flag=1, drop_cnt=2. Raise out_ready -> 1 then 2 appear, then out_valid=0.
5. Full with simultaneous push/pop: FIFO full, out_ready=1 and a new in_valid -> no drop, order preserved, drop_cnt unchanged.
6. Reset mid-stream: assert rst while 2 samples are in the pipeline and 2 are in the FIFO -> next cycle out_valid=0 and counters=0. The first post-reset sample appears at t+3 and is kept regardless of DECIM.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sum width derivation, output
// saturation limits and the round-half-up helper used by the output stage.
package fir_pkg;

    // Sum width produced by the distributed-arithmetic core for a given
    // sample width and tap count.
    function automatic int sum_width_calc(input int bit_width, input int taps);
        return bit_width + $clog2(taps) + $clog2(bit_width);
    endfunction

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_TAPS      = 32;
    localparam int DEF_SUM_WIDTH = sum_width_calc(DEF_BIT_WIDTH, DEF_TAPS);

    // Largest representable signed value of a bit_width-wide sample.
    function automatic logic signed [63:0] sat_max(input int bit_width);
        return (64'sd1 <<< (bit_width - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of a bit_width-wide sample.
    function automatic logic signed [63:0] sat_min(input int bit_width);
        return -(64'sd1 <<< (bit_width - 1));
    endfunction

    // Round half toward +inf while dropping frac_shift LSBs. The caller
    // sign-extends first, so adding the half-LSB can never wrap.
    function automatic logic signed [63:0] round_half_up(input logic signed [63:0] x,
                                                         input int frac_shift);
        return (x + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
    endfunction

endpackage

// File: rtl/fir_skid_fifo2.sv
// Two-entry valid/ready FIFO. The head entry is the registered output, so an
// empty FIFO presents a pushed word on the next cycle. A push into a full FIFO
// without a pop is ignored; the caller decides how to account for it.
module fir_skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty
);

    logic             head_v_r;
    logic             tail_v_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic             pop_s;

    assign pop_s      = pop && head_v_r;
    assign dout       = head_r;
    assign dout_valid = head_v_r;
    assign full       = head_v_r && tail_v_r;
    assign empty      = !head_v_r;

    // Storage update: pop shifts tail into head, push fills the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v_r <= 1'b0;
            tail_v_r <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
            tail_r   <= {WIDTH{1'b0}};
        end else begin
            case ({pop_s, push})
                2'b10: begin
                    if (tail_v_r) begin
                        head_r   <= tail_r;
                        tail_v_r <= 1'b0;
                    end else begin
                        head_v_r <= 1'b0;
                    end
                end
                2'b01: begin
                    if (!head_v_r) begin
                        head_r   <= din;
                        head_v_r <= 1'b1;
                    end else if (!tail_v_r) begin
                        tail_r   <= din;
                        tail_v_r <= 1'b1;
                    end else begin
                        head_r <= head_r;
                    end
                end
                2'b11: begin
                    if (tail_v_r) begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end else begin
                        head_r <= din;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output stage: round away FRAC_SHIFT LSBs, saturate to BIT_WIDTH,
// decimate by DECIM and buffer in a 2-entry valid/ready FIFO. Saturation and
// FIFO-overflow drops are reported through sticky flags and saturating counters.
module fir_out_quant
    import fir_pkg::*;
#(
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int FRAC_SHIFT = 8,
    parameter int DECIM      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [SUM_WIDTH-1:0] sum_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_data,
    output logic                        sat_flag,
    output logic                        ovf_flag,
    output logic [CNT_WIDTH-1:0]        sat_cnt,
    output logic [CNT_WIDTH-1:0]        drop_cnt,
    input  logic                        clr_flags
);

    // Rounded value keeps one guard MSB so near-full-scale sums cannot wrap.
    localparam int RW   = SUM_WIDTH + 1 - FRAC_SHIFT;
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]             PH_LAST   = PH_W'(DECIM - 1);
    localparam logic signed [63:0]          OUT_MAX64 = sat_max(BIT_WIDTH);
    localparam logic signed [63:0]          OUT_MIN64 = sat_min(BIT_WIDTH);
    localparam logic signed [BIT_WIDTH-1:0] OUT_MAX   = BIT_WIDTH'(OUT_MAX64);
    localparam logic signed [BIT_WIDTH-1:0] OUT_MIN   = BIT_WIDTH'(OUT_MIN64);
    localparam logic [CNT_WIDTH-1:0]        CNT_TOP   = {CNT_WIDTH{1'b1}};

    logic signed [63:0]          round64_s;
    logic                        s1_valid_r;
    logic signed [RW-1:0]        s1_round_r;
    logic signed [63:0]          s1_ext_s;
    logic signed [BIT_WIDTH-1:0] sat_val_s;
    logic                        clamp_s;
    logic                        keep_s;
    logic [PH_W-1:0]             phase_r;
    logic                        s2_valid_r;
    logic signed [BIT_WIDTH-1:0] s2_data_r;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        pop_s;
    logic                        sat_event_s;
    logic                        drop_event_s;
    logic                        unused_bits_s;

    assign round64_s     = round_half_up(64'(sum_in), FRAC_SHIFT);
    assign keep_s        = s1_valid_r && (phase_r == {PH_W{1'b0}});
    assign pop_s         = out_valid && out_ready;
    assign sat_event_s   = keep_s && clamp_s;
    assign drop_event_s  = s2_valid_r && fifo_full_s && !pop_s;
    assign unused_bits_s = ^{round64_s[63:RW], s1_ext_s[63:BIT_WIDTH], fifo_empty_s};

    // Stage 1: register the rounded sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_round_r <= {RW{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_round_r <= round64_s[RW-1:0];
            end
        end
    end

    // Clamp the rounded value to the signed output range.
    always_comb begin
        s1_ext_s  = 64'(s1_round_r);
        sat_val_s = s1_ext_s[BIT_WIDTH-1:0];
        clamp_s   = 1'b0;
        if (s1_ext_s > OUT_MAX64) begin
            sat_val_s = OUT_MAX;
            clamp_s   = 1'b1;
        end else if (s1_ext_s < OUT_MIN64) begin
            sat_val_s = OUT_MIN;
            clamp_s   = 1'b1;
        end else begin
            sat_val_s = s1_ext_s[BIT_WIDTH-1:0];
            clamp_s   = 1'b0;
        end
    end

    // Stage 2: keep the phase-0 sample of each DECIM group; phase moves on valid samples only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {BIT_WIDTH{1'b0}};
            phase_r    <= {PH_W{1'b0}};
        end else begin
            s2_valid_r <= keep_s;
            if (keep_s) begin
                s2_data_r <= sat_val_s;
            end
            if (s1_valid_r) begin
                phase_r <= (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_W'(1);
            end
        end
    end

    // Sticky flags and counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
            sat_cnt  <= {CNT_WIDTH{1'b0}};
            drop_cnt <= {CNT_WIDTH{1'b0}};
        end else if (clr_flags) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
            sat_cnt  <= {CNT_WIDTH{1'b0}};
            drop_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (sat_event_s) begin
                sat_flag <= 1'b1;
                if (sat_cnt != CNT_TOP) begin
                    sat_cnt <= sat_cnt + CNT_WIDTH'(1);
                end
            end
            if (drop_event_s) begin
                ovf_flag <= 1'b1;
                if (drop_cnt != CNT_TOP) begin
                    drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    fir_skid_fifo2 #(
        .WIDTH (BIT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s2_valid_r),
        .din        (s2_data_r),
        .pop        (pop_s),
        .dout       (out_data),
        .dout_valid (out_valid),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

endmodule

// File: tb/tb_fir_out_quant.sv
// Scoreboard bench for fir_out_quant: a transaction-level model predicts the
// accepted output stream, drops, saturations and flag state; a negedge monitor
// compares the DUT against it every cycle.
module tb_fir_out_quant;

    localparam int SW    = 25;
    localparam int BW    = 16;
    localparam int FS    = 8;
    localparam int DEC   = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam longint OMAX = (64'sd1 <<< (BW - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (BW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [SW-1:0] sum_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW-1:0] out_data;
    logic                 sat_flag;
    logic                 ovf_flag;
    logic [CW-1:0]        sat_cnt;
    logic [CW-1:0]        drop_cnt;
    logic                 clr_flags;

    fir_out_quant #(
        .SUM_WIDTH (SW),
        .BIT_WIDTH (BW),
        .FRAC_SHIFT(FS),
        .DECIM     (DEC),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag),
        .sat_cnt   (sat_cnt),
        .drop_cnt  (drop_cnt),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        longint val;
        bit     sat;
        int     sat_edge;
        int     push_edge;
    } item_t;

    item_t  pend[$];
    longint exp_q[$];
    int     exp_base = 0;
    int     edge_n = 0;
    int     mcnt = 0;
    int     vcount = 0;
    int     m_sat_cnt = 0;
    int     m_drop_cnt = 0;
    bit     m_sat_flag = 1'b0;
    bit     m_ovf_flag = 1'b0;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Model: one step per clock edge, driven only by bench-owned stimulus.
    always @(posedge clk) begin
        bit     pop;
        bit     push;
        bit     sat_ev;
        bit     drop_ev;
        longint pv;
        longint r;
        item_t  it;
        edge_n = edge_n + 1;
        if (rst) begin
            pend.delete();
            mcnt       = 0;
            vcount     = 0;
            m_sat_cnt  = 0;
            m_drop_cnt = 0;
            m_sat_flag = 1'b0;
            m_ovf_flag = 1'b0;
            exp_base   = exp_q.size();
        end else begin
            pop     = (mcnt > 0) && out_ready;
            push    = 1'b0;
            sat_ev  = 1'b0;
            drop_ev = 1'b0;
            pv      = 0;
            foreach (pend[i]) if (pend[i].sat_edge == edge_n && pend[i].sat) sat_ev = 1'b1;
            if (pend.size() > 0 && pend[0].push_edge == edge_n) begin
                push = 1'b1;
                pv   = pend[0].val;
                void'(pend.pop_front());
            end
            if (push && mcnt == 2 && !pop) drop_ev = 1'b1;
            else if (push) exp_q.push_back(pv);
            mcnt = mcnt - (pop ? 1 : 0) + ((push && !drop_ev) ? 1 : 0);
            if (clr_flags) begin
                m_sat_cnt  = 0;
                m_drop_cnt = 0;
                m_sat_flag = 1'b0;
                m_ovf_flag = 1'b0;
            end else begin
                if (sat_ev) begin
                    m_sat_flag = 1'b1;
                    if (m_sat_cnt < CMAX) m_sat_cnt = m_sat_cnt + 1;
                end
                if (drop_ev) begin
                    m_ovf_flag = 1'b1;
                    if (m_drop_cnt < CMAX) m_drop_cnt = m_drop_cnt + 1;
                end
            end
            if (in_valid) begin
                if (vcount % DEC == 0) begin
                    r = floor_div(longint'(sum_in) + (64'sd1 <<< (FS - 1)), 64'sd1 <<< FS);
                    it.sat = (r > OMAX) || (r < OMIN);
                    it.val = (r > OMAX) ? OMAX : ((r < OMIN) ? OMIN : r);
                    it.sat_edge  = edge_n + 1;
                    it.push_edge = edge_n + 2;
                    pend.push_back(it);
                end
                vcount = vcount + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int rd_idx = 0;
    bit mon_en = 1'b0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;

    function automatic void chk(input string name, input longint act, input longint req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Compare DUT state against the model each cycle, popping the scoreboard on handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_idx < exp_base) rd_idx = exp_base;
            chk("out_valid", longint'(out_valid), (mcnt > 0) ? 1 : 0);
            chk("sat_flag", longint'(sat_flag), longint'(m_sat_flag));
            chk("ovf_flag", longint'(ovf_flag), longint'(m_ovf_flag));
            chk("sat_cnt", longint'(sat_cnt), longint'(m_sat_cnt));
            chk("drop_cnt", longint'(drop_cnt), longint'(m_drop_cnt));
            if (out_valid && out_ready) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("out_data_unexpected", longint'(out_data), 0);
                    errors = (longint'(out_data) == 0) ? errors + 1 : errors;
                end else begin
                    chk("out_data", longint'(out_data), exp_q[rd_idx]);
                    rd_idx = rd_idx + 1;
                end
            end
            if (end_req && !end_done) begin
                chk("drained", rd_idx, exp_q.size());
                end_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint v);
        in_valid = 1'b1;
        sum_in   = SW'(v);
        tick();
        in_valid = 1'b0;
    endtask

    // Send v so that it lands on decimation phase 0 (caller keeps groups aligned).
    task automatic send_kept(input longint v);
        send(v);
        send(0);
        send(0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic longint rand_sum();
        longint v;
        case ($urandom_range(0, 4))
            0: v = longint'($urandom_range(0, 4000)) - 2000;
            1: v = 8388607 - longint'($urandom_range(0, 20000));
            2: v = -8388608 + longint'($urandom_range(0, 20000));
            3: v = (longint'($urandom_range(0, 2000)) - 1000) * 256 + 128;
            default: begin
                v = longint'($urandom_range(0, (1 << SW) - 1));
                if (v >= (64'sd1 <<< (SW - 1))) v = v - (64'sd1 <<< SW);
            end
        endcase
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sum_in    = '0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Rounding, including ties on both sides of zero.
        send_kept(384);
        send_kept(-384);
        send_kept(127);
        send_kept(128);
        send_kept(-128);
        send_kept(-129);
        idle(5);

        // Saturation at both ends, then clear.
        send_kept(8388607);
        send_kept(-16777216);
        idle(5);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        idle(2);

        // Decimation with a continuous stream.
        for (int k = 0; k < 9; k++) send(k * 256);
        idle(6);

        // Backpressure: two held, two dropped, then drain.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_kept(k * 256);
        idle(4);
        out_ready = 1'b1;
        idle(5);

        // Full FIFO receiving a push in the same cycle as a pop.
        out_ready = 1'b0;
        send_kept(10 * 256);
        send_kept(11 * 256);
        idle(3);
        send(12 * 256);
        out_ready = 1'b1;
        send(0);
        send(0);
        idle(6);

        // Counter saturation at all-ones.
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) send_kept(8388000);
        out_ready = 1'b1;
        idle(6);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Reset mid-stream with phase left non-zero.
        out_ready = 1'b0;
        send_kept(20 * 256);
        send_kept(21 * 256);
        send(22 * 256);
        send(23 * 256);
        in_valid = 1'b1;
        sum_in   = SW'(24 * 256);
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(30 * 256);
        send(31 * 256);
        idle(6);

        // Randomised traffic with occasional clears and resets.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            sum_in    = SW'(rand_sum());
            out_ready = ($urandom_range(0, 2) != 0);
            clr_flags = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(10);
        end_req = 1'b1;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
